// File: rtl/rvh_ptw_mem_bridge_if.sv
// ---------------------------------------------------------------------------
// rvh_ptw_mem_bridge_if
//   Bundles the walker-side and memory-side handshakes of the PTW memory
//   bridge, plus its status outputs.
//
//   slave  modport : the bridge itself
//   master modport : the surroundings (walker + memory port)
//
//   Walker request  : ptw_walk_req_vld_i / _id_i / _addr_i, ptw_walk_req_rdy_o
//   Walker response : ptw_walk_resp_vld_o / _pte_o, ptw_walk_resp_rdy_i
//   Memory request  : mem_req_vld_o / _tag_o / _addr_o, mem_req_rdy_i
//   Memory response : mem_resp_vld_i / _tag_i / _data_i / _err_i
//   Status          : outstanding_cnt_o, protocol_err_o
// ---------------------------------------------------------------------------
interface rvh_ptw_mem_bridge_if #(
  parameter int PADDR_WIDTH  = 56,
  parameter int PTW_ID_WIDTH = 1,
  parameter int PTE_WIDTH    = 64,
  parameter int TAG_WIDTH    = 2
);

  logic                    ptw_walk_req_vld_i;
  logic [PTW_ID_WIDTH-1:0] ptw_walk_req_id_i;
  logic [PADDR_WIDTH-1:0]  ptw_walk_req_addr_i;
  logic                    ptw_walk_req_rdy_o;

  logic                    ptw_walk_resp_vld_o;
  logic [PTE_WIDTH-1:0]    ptw_walk_resp_pte_o;
  logic                    ptw_walk_resp_rdy_i;

  logic                    mem_req_vld_o;
  logic [TAG_WIDTH-1:0]    mem_req_tag_o;
  logic [PADDR_WIDTH-1:0]  mem_req_addr_o;
  logic                    mem_req_rdy_i;

  logic                    mem_resp_vld_i;
  logic [TAG_WIDTH-1:0]    mem_resp_tag_i;
  logic [PTE_WIDTH-1:0]    mem_resp_data_i;
  logic                    mem_resp_err_i;

  logic [TAG_WIDTH:0]      outstanding_cnt_o;
  logic                    protocol_err_o;

  modport slave (
    input  ptw_walk_req_vld_i, ptw_walk_req_id_i, ptw_walk_req_addr_i,
    output ptw_walk_req_rdy_o,
    output ptw_walk_resp_vld_o, ptw_walk_resp_pte_o,
    input  ptw_walk_resp_rdy_i,
    output mem_req_vld_o, mem_req_tag_o, mem_req_addr_o,
    input  mem_req_rdy_i,
    input  mem_resp_vld_i, mem_resp_tag_i, mem_resp_data_i, mem_resp_err_i,
    output outstanding_cnt_o, protocol_err_o
  );

  modport master (
    output ptw_walk_req_vld_i, ptw_walk_req_id_i, ptw_walk_req_addr_i,
    input  ptw_walk_req_rdy_o,
    input  ptw_walk_resp_vld_o, ptw_walk_resp_pte_o,
    output ptw_walk_resp_rdy_i,
    input  mem_req_vld_o, mem_req_tag_o, mem_req_addr_o,
    output mem_req_rdy_i,
    output mem_resp_vld_i, mem_resp_tag_i, mem_resp_data_i, mem_resp_err_i,
    input  outstanding_cnt_o, protocol_err_o
  );

endinterface

// File: rtl/rvh_ptw_mem_bridge.sv
// ---------------------------------------------------------------------------
// rvh_ptw_mem_bridge
//   Turns page-table-walker PTE fetches into tagged 64-bit memory reads and
//   returns the PTEs to the walker strictly in request order, even when the
//   memory answers out of order. Bus errors and misaligned PTE addresses come
//   back as an all-zero PTE (V=0) so the walker raises a page fault.
//
//   Ports:
//     clk  - clock
//     rst  - synchronous, active-high reset
//     bus  - rvh_ptw_mem_bridge_if.slave (walker req/resp, memory req/resp,
//            outstanding_cnt_o, protocol_err_o)
// ---------------------------------------------------------------------------
module rvh_ptw_mem_bridge #(
  parameter int PADDR_WIDTH     = 56,
  parameter int PTW_ID_WIDTH    = 1,
  parameter int PTE_WIDTH       = 64,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TAG_WIDTH       = 2
) (
  input  logic                clk,
  input  logic                rst,
  rvh_ptw_mem_bridge_if.slave bus
);

  // ISSUE is kept as a reserved encoding; slots never enter it.
  typedef enum logic [1:0] {
    SLOT_FREE  = 2'd0,
    SLOT_ISSUE = 2'd1,
    SLOT_PEND  = 2'd2,
    SLOT_DONE  = 2'd3
  } slot_state_e;

  slot_state_e             slot_state_q [MAX_OUTSTANDING];
  slot_state_e             slot_state_d [MAX_OUTSTANDING];
  logic [PTE_WIDTH-1:0]    slot_data_q  [MAX_OUTSTANDING];
  logic [PTE_WIDTH-1:0]    slot_data_d  [MAX_OUTSTANDING];
  logic [PTW_ID_WIDTH-1:0] slot_id_q    [MAX_OUTSTANDING];
  logic [PTW_ID_WIDTH-1:0] slot_id_d    [MAX_OUTSTANDING];
  logic [PADDR_WIDTH-1:0]  slot_addr_q  [MAX_OUTSTANDING];
  logic [PADDR_WIDTH-1:0]  slot_addr_d  [MAX_OUTSTANDING];

  logic [TAG_WIDTH-1:0]    head_q, head_d;
  logic [TAG_WIDTH-1:0]    tail_q, tail_d;
  logic                    mem_req_vld_q, mem_req_vld_d;
  logic [TAG_WIDTH-1:0]    mem_req_tag_q, mem_req_tag_d;
  logic                    resp_vld_q, resp_vld_d;
  logic [PTE_WIDTH-1:0]    resp_pte_q, resp_pte_d;
  logic                    proto_err_q, proto_err_d;

  logic                    req_rdy;
  logic                    accept;
  logic                    resp_hit;
  logic [PTE_WIDTH-1:0]    resp_value;
  logic                    head_bypass;
  logic                    out_free;
  logic [TAG_WIDTH:0]      outstanding_cnt;
  logic                    unused_slot_id;

  // A slot can be claimed only when it is FREE and the single memory request
  // register is empty or draining this cycle.
  assign req_rdy = (slot_state_q[tail_q] == SLOT_FREE) &&
                   (!mem_req_vld_q || bus.mem_req_rdy_i);
  assign accept  = bus.ptw_walk_req_vld_i && req_rdy;

  assign resp_hit   = bus.mem_resp_vld_i &&
                      (slot_state_q[bus.mem_resp_tag_i] == SLOT_PEND);
  assign resp_value = bus.mem_resp_err_i ? '0 : bus.mem_resp_data_i;

  // Data for the head slot goes straight into the output register so the
  // walker sees it the cycle after the memory response.
  assign head_bypass = resp_hit && (bus.mem_resp_tag_i == head_q);
  assign out_free    = !resp_vld_q || bus.ptw_walk_resp_rdy_i;

  // Next-state for slots, pointers, the memory request register and the
  // walker response register. The three event sources touch distinct slots:
  // tail is FREE, a response hits a PEND slot, and the head load uses a DONE
  // slot (or the PEND head being bypassed, where the load's FREE wins).
  always_comb begin
    slot_state_d  = slot_state_q;
    slot_data_d   = slot_data_q;
    slot_id_d     = slot_id_q;
    slot_addr_d   = slot_addr_q;
    head_d        = head_q;
    tail_d        = tail_q;
    mem_req_vld_d = mem_req_vld_q;
    mem_req_tag_d = mem_req_tag_q;
    resp_vld_d    = resp_vld_q;
    resp_pte_d    = resp_pte_q;
    proto_err_d   = proto_err_q;

    if (mem_req_vld_q && bus.mem_req_rdy_i) begin
      mem_req_vld_d = 1'b0;
    end

    if (accept) begin
      slot_id_d[tail_q]   = bus.ptw_walk_req_id_i;
      slot_addr_d[tail_q] = bus.ptw_walk_req_addr_i;
      if (bus.ptw_walk_req_addr_i[2:0] == 3'b000) begin
        slot_state_d[tail_q] = SLOT_PEND;
        mem_req_vld_d        = 1'b1;
        mem_req_tag_d        = tail_q;
      end else begin
        slot_state_d[tail_q] = SLOT_DONE;
        slot_data_d[tail_q]  = '0;
      end
      tail_d = tail_q + TAG_WIDTH'(1);
    end

    if (resp_hit) begin
      slot_state_d[bus.mem_resp_tag_i] = SLOT_DONE;
      slot_data_d[bus.mem_resp_tag_i]  = resp_value;
    end else if (bus.mem_resp_vld_i) begin
      proto_err_d = 1'b1;
    end

    if (resp_vld_q && bus.ptw_walk_resp_rdy_i) begin
      resp_vld_d = 1'b0;
    end

    if (out_free && ((slot_state_q[head_q] == SLOT_DONE) || head_bypass)) begin
      resp_vld_d           = 1'b1;
      resp_pte_d           = head_bypass ? resp_value : slot_data_q[head_q];
      slot_state_d[head_q] = SLOT_FREE;
      head_d               = head_q + TAG_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        slot_state_q[i] <= SLOT_FREE;
        slot_data_q[i]  <= '0;
        slot_id_q[i]    <= '0;
        slot_addr_q[i]  <= '0;
      end
      head_q        <= '0;
      tail_q        <= '0;
      mem_req_vld_q <= 1'b0;
      mem_req_tag_q <= '0;
      resp_vld_q    <= 1'b0;
      resp_pte_q    <= '0;
      proto_err_q   <= 1'b0;
    end else begin
      slot_state_q  <= slot_state_d;
      slot_data_q   <= slot_data_d;
      slot_id_q     <= slot_id_d;
      slot_addr_q   <= slot_addr_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      mem_req_vld_q <= mem_req_vld_d;
      mem_req_tag_q <= mem_req_tag_d;
      resp_vld_q    <= resp_vld_d;
      resp_pte_q    <= resp_pte_d;
      proto_err_q   <= proto_err_d;
    end
  end

  // Occupied slots plus an unconsumed response sitting in the output register.
  always_comb begin
    outstanding_cnt = '0;
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      if (slot_state_q[i] != SLOT_FREE) begin
        outstanding_cnt = outstanding_cnt + (TAG_WIDTH+1)'(1);
      end
    end
    if (resp_vld_q) begin
      outstanding_cnt = outstanding_cnt + (TAG_WIDTH+1)'(1);
    end
  end

  // The walker id is kept per slot purely for debug visibility.
  always_comb begin
    unused_slot_id = 1'b0;
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      unused_slot_id = unused_slot_id ^ (^slot_id_q[i]);
    end
  end

  // The issued address is read from the slot named by the request register;
  // a PEND slot's address cannot change, so the request holds stable.
  assign bus.ptw_walk_req_rdy_o  = req_rdy;
  assign bus.ptw_walk_resp_vld_o = resp_vld_q;
  assign bus.ptw_walk_resp_pte_o = resp_pte_q;
  assign bus.mem_req_vld_o       = mem_req_vld_q;
  assign bus.mem_req_tag_o       = mem_req_tag_q;
  assign bus.mem_req_addr_o      = slot_addr_q[mem_req_tag_q];
  assign bus.outstanding_cnt_o   = outstanding_cnt;
  assign bus.protocol_err_o      = proto_err_q;

endmodule

// File: tb/tb_rvh_ptw_mem_bridge.sv
// ---------------------------------------------------------------------------
// tb_rvh_ptw_mem_bridge
//   Directed bench for rvh_ptw_mem_bridge. Inputs change 1 time unit after a
//   rising edge; outputs are sampled at that same point.
// ---------------------------------------------------------------------------
module tb_rvh_ptw_mem_bridge;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  rvh_ptw_mem_bridge_if #(
    .PADDR_WIDTH(56), .PTW_ID_WIDTH(1), .PTE_WIDTH(64), .TAG_WIDTH(2)
  ) bus ();

  rvh_ptw_mem_bridge #(
    .PADDR_WIDTH(56), .PTW_ID_WIDTH(1), .PTE_WIDTH(64),
    .MAX_OUTSTANDING(4), .TAG_WIDTH(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // One-cycle memory response; other inputs keep whatever the caller set.
  task automatic mem_respond(input logic [1:0] tag, input logic [63:0] data,
                             input logic err);
    bus.mem_resp_vld_i  = 1'b1;
    bus.mem_resp_tag_i  = tag;
    bus.mem_resp_data_i = data;
    bus.mem_resp_err_i  = err;
    tick();
    bus.mem_resp_vld_i  = 1'b0;
    bus.mem_resp_err_i  = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if ({bus.ptw_walk_resp_vld_o, bus.ptw_walk_resp_pte_o} !== 65'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_resp got vld=%0b pte=%h exp 0", bus.ptw_walk_resp_vld_o, bus.ptw_walk_resp_pte_o);
    end
    tests_run++;
    if ({bus.mem_req_vld_o, bus.mem_req_tag_o, bus.mem_req_addr_o} !== 59'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_memreq got vld=%0b tag=%0d addr=%h exp 0", bus.mem_req_vld_o, bus.mem_req_tag_o, bus.mem_req_addr_o);
    end
    tests_run++;
    if ({bus.outstanding_cnt_o, bus.protocol_err_o, bus.ptw_walk_req_rdy_o} !== 5'b00001) begin
      tests_failed++;
      $display("[TB] FAIL reset_status got cnt=%0d perr=%0b rdy=%0b exp 0/0/1", bus.outstanding_cnt_o, bus.protocol_err_o, bus.ptw_walk_req_rdy_o);
    end
  endtask

  task automatic test_single();
    do_reset();
    bus.ptw_walk_req_vld_i  = 1'b1;
    bus.ptw_walk_req_id_i   = 1'b1;
    bus.ptw_walk_req_addr_i = 56'h0000_0080_001008 >> 4 << 4 | 56'h8;
    bus.ptw_walk_req_addr_i = 56'h8000_1008;
    tick();
    bus.ptw_walk_req_vld_i  = 1'b0;
    tests_run++;
    if ({bus.mem_req_vld_o, bus.mem_req_tag_o, bus.mem_req_addr_o} !== {1'b1, 2'd0, 56'h8000_1008}) begin
      tests_failed++;
      $display("[TB] FAIL single_memreq got vld=%0b tag=%0d addr=%h exp 1/0/80001008", bus.mem_req_vld_o, bus.mem_req_tag_o, bus.mem_req_addr_o);
    end
    tests_run++;
    if (bus.outstanding_cnt_o !== 3'd1) begin
      tests_failed++;
      $display("[TB] FAIL single_cnt_pend got %0d exp 1", bus.outstanding_cnt_o);
    end
    tick();
    mem_respond(2'd0, 64'h2000_00CF, 1'b0);
    tests_run++;
    if ({bus.ptw_walk_resp_vld_o, bus.ptw_walk_resp_pte_o} !== {1'b1, 64'h2000_00CF}) begin
      tests_failed++;
      $display("[TB] FAIL single_resp got vld=%0b pte=%h exp 1/200000cf", bus.ptw_walk_resp_vld_o, bus.ptw_walk_resp_pte_o);
    end
    tick();
    tests_run++;
    if ({bus.ptw_walk_resp_vld_o, bus.outstanding_cnt_o} !== 4'b0_000) begin
      tests_failed++;
      $display("[TB] FAIL single_drain got vld=%0b cnt=%0d exp 0/0", bus.ptw_walk_resp_vld_o, bus.outstanding_cnt_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [55:0] addr_v [5];
    logic [63:0] data_v [5];
    for (int i = 0; i < 5; i++) begin
      addr_v[i] = 56'h0080_2000 + 56'(i * 16);
      data_v[i] = {8'hCA, addr_v[i]};
    end
    do_reset();
    bus.ptw_walk_req_vld_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.ptw_walk_req_addr_i = addr_v[i];
      tests_run++;
      if (bus.ptw_walk_req_rdy_o !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL b2b_rdy_%0d got %0b exp 1", i, bus.ptw_walk_req_rdy_o);
      end
      tick();
      tests_run++;
      if ({bus.mem_req_vld_o, bus.mem_req_tag_o, bus.mem_req_addr_o} !== {1'b1, 2'(i), addr_v[i]}) begin
        tests_failed++;
        $display("[TB] FAIL b2b_memreq_%0d got vld=%0b tag=%0d addr=%h exp tag %0d addr %h", i, bus.mem_req_vld_o, bus.mem_req_tag_o, bus.mem_req_addr_o, i, addr_v[i]);
      end
    end
    bus.ptw_walk_req_vld_i = 1'b0;
    tests_run++;
    if ({bus.ptw_walk_req_rdy_o, bus.outstanding_cnt_o} !== {1'b0, 3'd4}) begin
      tests_failed++;
      $display("[TB] FAIL b2b_full got rdy=%0b cnt=%0d exp 0/4", bus.ptw_walk_req_rdy_o, bus.outstanding_cnt_o);
    end
    mem_respond(2'd3, data_v[3], 1'b0);
    mem_respond(2'd1, data_v[1], 1'b0);
    tests_run++;
    if (bus.ptw_walk_resp_vld_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL b2b_hold_ooo got vld=%0b exp 0", bus.ptw_walk_resp_vld_o);
    end
    mem_respond(2'd0, data_v[0], 1'b0);
    tests_run++;
    if ({bus.ptw_walk_resp_vld_o, bus.ptw_walk_resp_pte_o} !== {1'b1, data_v[0]}) begin
      tests_failed++;
      $display("[TB] FAIL b2b_pte0 got vld=%0b pte=%h exp %h", bus.ptw_walk_resp_vld_o, bus.ptw_walk_resp_pte_o, data_v[0]);
    end
    tests_run++;
    if ({bus.ptw_walk_req_rdy_o, bus.outstanding_cnt_o} !== {1'b1, 3'd4}) begin
      tests_failed++;
      $display("[TB] FAIL b2b_slot0_free got rdy=%0b cnt=%0d exp 1/4", bus.ptw_walk_req_rdy_o, bus.outstanding_cnt_o);
    end
    bus.ptw_walk_req_vld_i  = 1'b1;
    bus.ptw_walk_req_addr_i = addr_v[4];
    mem_respond(2'd2, data_v[2], 1'b0);
    bus.ptw_walk_req_vld_i  = 1'b0;
    tests_run++;
    if ({bus.ptw_walk_resp_vld_o, bus.ptw_walk_resp_pte_o} !== {1'b1, data_v[1]}) begin
      tests_failed++;
      $display("[TB] FAIL b2b_pte1 got vld=%0b pte=%h exp %h", bus.ptw_walk_resp_vld_o, bus.ptw_walk_resp_pte_o, data_v[1]);
    end
    tests_run++;
    if ({bus.mem_req_vld_o, bus.mem_req_tag_o, bus.mem_req_addr_o} !== {1'b1, 2'd0, addr_v[4]}) begin
      tests_failed++;
      $display("[TB] FAIL b2b_fifth got vld=%0b tag=%0d addr=%h exp 1/0/%h", bus.mem_req_vld_o, bus.mem_req_tag_o, bus.mem_req_addr_o, addr_v[4]);
    end
    for (int i = 2; i < 4; i++) begin
      tick();
      tests_run++;
      if ({bus.ptw_walk_resp_vld_o, bus.ptw_walk_resp_pte_o} !== {1'b1, data_v[i]}) begin
        tests_failed++;
        $display("[TB] FAIL b2b_pte%0d got vld=%0b pte=%h exp %h", i, bus.ptw_walk_resp_vld_o, bus.ptw_walk_resp_pte_o, data_v[i]);
      end
    end
    mem_respond(2'd0, data_v[4], 1'b0);
    tests_run++;
    if ({bus.ptw_walk_resp_vld_o, bus.ptw_walk_resp_pte_o} !== {1'b1, data_v[4]}) begin
      tests_failed++;
      $display("[TB] FAIL b2b_pte4 got vld=%0b pte=%h exp %h", bus.ptw_walk_resp_vld_o, bus.ptw_walk_resp_pte_o, data_v[4]);
    end
    tick();
    tests_run++;
    if ({bus.ptw_walk_resp_vld_o, bus.outstanding_cnt_o} !== 4'b0_000) begin
      tests_failed++;
      $display("[TB] FAIL b2b_drain got vld=%0b cnt=%0d exp 0/0", bus.ptw_walk_resp_vld_o, bus.outstanding_cnt_o);
    end
  endtask

  task automatic test_bus_error();
    do_reset();
    bus.ptw_walk_req_vld_i  = 1'b1;
    bus.ptw_walk_req_addr_i = 56'h3000;
    tick();
    bus.ptw_walk_req_vld_i  = 1'b0;
    tick();
    mem_respond(2'd0, 64'hFFFF, 1'b1);
    tests_run++;
    if ({bus.ptw_walk_resp_vld_o, bus.ptw_walk_resp_pte_o} !== {1'b1, 64'h0}) begin
      tests_failed++;
      $display("[TB] FAIL buserr_pte got vld=%0b pte=%h exp 1/0", bus.ptw_walk_resp_vld_o, bus.ptw_walk_resp_pte_o);
    end
    tick();
  endtask

  task automatic test_misaligned();
    do_reset();
    bus.ptw_walk_req_vld_i  = 1'b1;
    bus.ptw_walk_req_addr_i = 56'h4000;
    tick();
    bus.ptw_walk_req_addr_i = 56'h1004;
    tick();
    bus.ptw_walk_req_vld_i  = 1'b0;
    tests_run++;
    if ({bus.mem_req_vld_o, bus.ptw_walk_resp_vld_o, bus.outstanding_cnt_o} !== {2'b00, 3'd2}) begin
      tests_failed++;
      $display("[TB] FAIL misal_noreq got memvld=%0b rvld=%0b cnt=%0d exp 0/0/2", bus.mem_req_vld_o, bus.ptw_walk_resp_vld_o, bus.outstanding_cnt_o);
    end
    tick();
    tests_run++;
    if ({bus.mem_req_vld_o, bus.ptw_walk_resp_vld_o} !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL misal_waits got memvld=%0b rvld=%0b exp 0/0", bus.mem_req_vld_o, bus.ptw_walk_resp_vld_o);
    end
    mem_respond(2'd0, 64'h0000_0000_1234_5601, 1'b0);
    tests_run++;
    if ({bus.ptw_walk_resp_vld_o, bus.ptw_walk_resp_pte_o} !== {1'b1, 64'h1234_5601}) begin
      tests_failed++;
      $display("[TB] FAIL misal_first got vld=%0b pte=%h exp 1/12345601", bus.ptw_walk_resp_vld_o, bus.ptw_walk_resp_pte_o);
    end
    tick();
    tests_run++;
    if ({bus.ptw_walk_resp_vld_o, bus.ptw_walk_resp_pte_o} !== {1'b1, 64'h0}) begin
      tests_failed++;
      $display("[TB] FAIL misal_zero got vld=%0b pte=%h exp 1/0", bus.ptw_walk_resp_vld_o, bus.ptw_walk_resp_pte_o);
    end
    tick();
    tests_run++;
    if ({bus.ptw_walk_resp_vld_o, bus.outstanding_cnt_o} !== 4'b0_000) begin
      tests_failed++;
      $display("[TB] FAIL misal_drain got vld=%0b cnt=%0d exp 0/0", bus.ptw_walk_resp_vld_o, bus.outstanding_cnt_o);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.ptw_walk_resp_rdy_i = 1'b0;
    bus.ptw_walk_req_vld_i  = 1'b1;
    bus.ptw_walk_req_addr_i = 56'h6000;
    tick();
    bus.ptw_walk_req_addr_i = 56'h6008;
    tick();
    bus.ptw_walk_req_vld_i  = 1'b0;
    mem_respond(2'd0, 64'hB000_0000_0000_00C1, 1'b0);
    mem_respond(2'd1, 64'hB000_0000_0000_00C3, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tests_run++;
      if ({bus.ptw_walk_resp_vld_o, bus.ptw_walk_resp_pte_o} !== {1'b1, 64'hB000_0000_0000_00C1}) begin
        tests_failed++;
        $display("[TB] FAIL bp_hold_%0d got vld=%0b pte=%h exp 1/b0000000000000c1", i, bus.ptw_walk_resp_vld_o, bus.ptw_walk_resp_pte_o);
      end
      tick();
    end
    tests_run++;
    if (bus.outstanding_cnt_o !== 3'd2) begin
      tests_failed++;
      $display("[TB] FAIL bp_cnt got %0d exp 2", bus.outstanding_cnt_o);
    end
    bus.ptw_walk_resp_rdy_i = 1'b1;
    tick();
    tests_run++;
    if ({bus.ptw_walk_resp_vld_o, bus.ptw_walk_resp_pte_o} !== {1'b1, 64'hB000_0000_0000_00C3}) begin
      tests_failed++;
      $display("[TB] FAIL bp_second got vld=%0b pte=%h exp 1/b0000000000000c3", bus.ptw_walk_resp_vld_o, bus.ptw_walk_resp_pte_o);
    end
    tick();
    tests_run++;
    if ({bus.ptw_walk_resp_vld_o, bus.outstanding_cnt_o} !== 4'b0_000) begin
      tests_failed++;
      $display("[TB] FAIL bp_drain got vld=%0b cnt=%0d exp 0/0", bus.ptw_walk_resp_vld_o, bus.outstanding_cnt_o);
    end
    // Memory-side stall: the issued request must stay put.
    bus.mem_req_rdy_i       = 1'b0;
    bus.ptw_walk_req_vld_i  = 1'b1;
    bus.ptw_walk_req_addr_i = 56'h7008;
    tick();
    bus.ptw_walk_req_addr_i = 56'h7010;
    tests_run++;
    if (bus.ptw_walk_req_rdy_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL stall_rdy got %0b exp 0", bus.ptw_walk_req_rdy_o);
    end
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if ({bus.mem_req_vld_o, bus.mem_req_tag_o, bus.mem_req_addr_o} !== {1'b1, 2'd2, 56'h7008}) begin
        tests_failed++;
        $display("[TB] FAIL stall_hold_%0d got vld=%0b tag=%0d addr=%h exp 1/2/7008", i, bus.mem_req_vld_o, bus.mem_req_tag_o, bus.mem_req_addr_o);
      end
      tick();
    end
    bus.ptw_walk_req_vld_i = 1'b0;
    bus.mem_req_rdy_i      = 1'b1;
    tick();
    tests_run++;
    if (bus.mem_req_vld_o !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL stall_release got %0b exp 0", bus.mem_req_vld_o);
    end
    mem_respond(2'd2, 64'h77, 1'b0);
    tests_run++;
    if ({bus.ptw_walk_resp_vld_o, bus.ptw_walk_resp_pte_o} !== {1'b1, 64'h77}) begin
      tests_failed++;
      $display("[TB] FAIL stall_resp got vld=%0b pte=%h exp 1/77", bus.ptw_walk_resp_vld_o, bus.ptw_walk_resp_pte_o);
    end
    tick();
  endtask

  task automatic test_protocol_and_reset();
    do_reset();
    mem_respond(2'd2, 64'h55, 1'b0);
    tests_run++;
    if ({bus.protocol_err_o, bus.ptw_walk_resp_vld_o, bus.outstanding_cnt_o} !== {2'b10, 3'd0}) begin
      tests_failed++;
      $display("[TB] FAIL perr_free got perr=%0b vld=%0b cnt=%0d exp 1/0/0", bus.protocol_err_o, bus.ptw_walk_resp_vld_o, bus.outstanding_cnt_o);
    end
    bus.ptw_walk_req_vld_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.ptw_walk_req_addr_i = 56'h9000 + 56'(i * 8);
      tick();
    end
    bus.ptw_walk_req_vld_i = 1'b0;
    tests_run++;
    if (bus.outstanding_cnt_o !== 3'd3) begin
      tests_failed++;
      $display("[TB] FAIL midrst_pending got %0d exp 3", bus.outstanding_cnt_o);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests_run++;
    if ({bus.ptw_walk_resp_vld_o, bus.ptw_walk_resp_pte_o, bus.mem_req_vld_o, bus.mem_req_tag_o,
         bus.mem_req_addr_o, bus.outstanding_cnt_o, bus.protocol_err_o} !== 128'h0) begin
      tests_failed++;
      $display("[TB] FAIL midrst_outputs got rvld=%0b pte=%h mvld=%0b tag=%0d addr=%h cnt=%0d perr=%0b exp all 0", bus.ptw_walk_resp_vld_o, bus.ptw_walk_resp_pte_o, bus.mem_req_vld_o, bus.mem_req_tag_o, bus.mem_req_addr_o, bus.outstanding_cnt_o, bus.protocol_err_o);
    end
    tests_run++;
    if (bus.ptw_walk_req_rdy_o !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL midrst_rdy got %0b exp 1", bus.ptw_walk_req_rdy_o);
    end
    mem_respond(2'd1, 64'h66, 1'b0);
    tests_run++;
    if ({bus.protocol_err_o, bus.ptw_walk_resp_vld_o} !== 2'b10) begin
      tests_failed++;
      $display("[TB] FAIL late_resp got perr=%0b vld=%0b exp 1/0", bus.protocol_err_o, bus.ptw_walk_resp_vld_o);
    end
  endtask

  initial begin
    tests_run               = 0;
    tests_failed            = 0;
    rst                     = 1'b1;
    bus.ptw_walk_req_vld_i  = 1'b0;
    bus.ptw_walk_req_id_i   = 1'b0;
    bus.ptw_walk_req_addr_i = '0;
    bus.ptw_walk_resp_rdy_i = 1'b1;
    bus.mem_req_rdy_i       = 1'b1;
    bus.mem_resp_vld_i      = 1'b0;
    bus.mem_resp_tag_i      = '0;
    bus.mem_resp_data_i     = '0;
    bus.mem_resp_err_i      = 1'b0;

    test_reset();
    test_single();
    test_back_to_back();
    test_bus_error();
    test_misaligned();
    test_backpressure();
    test_protocol_and_reset();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
